// File: rtl/text_flush_buffer.sv
// Command filter in front of a text renderer: holds TEX/PAL cell planes written by
// in-band commands and streams them downstream as a burst on a flush command.
module text_flush_buffer #(
    parameter int COLS           = 43,
    parameter int ROWS           = 24,
    parameter int XW             = 6,
    parameter int YW             = 5,
    parameter int DW             = 8,
    parameter int CLEAR_ON_FLUSH = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [23:0]   in,
    input  logic          start,
    output logic [23:0]   nin,
    output logic          nstart,
    output logic          busy,
    output logic          irq,
    output logic          ovf,
    output logic [XW-1:0] loadx,
    output logic [YW-1:0] loady
);

    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);
    localparam logic [XW-1:0] XMAX = XW'(COLS - 1);
    localparam logic [YW-1:0] YMAX = YW'(ROWS - 1);

    localparam logic [7:0] OP_SETX  = 8'd10;
    localparam logic [7:0] OP_SETY  = 8'd11;
    localparam logic [7:0] OP_WTEX  = 8'd12;
    localparam logic [7:0] OP_WPAL  = 8'd13;
    localparam logic [7:0] OP_ZERO  = 8'd254;
    localparam logic [7:0] OP_FLUSH = 8'd253;
    localparam logic [7:0] OP_BTEX  = 8'd244;
    localparam logic [7:0] OP_BPAL  = 8'd252;

    typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

    state_t        state;
    logic [XW-1:0] cur_x, px;
    logic [YW-1:0] cur_y, py;
    logic          ph, last_q, both_q, pal_only_q, emit_pal_q;

    logic [DW-1:0] tex_mem [0:CELLS-1];
    logic [DW-1:0] pal_mem [0:CELLS-1];

    logic [7:0]    op;
    logic [XW-1:0] dec_x, sat_x, adv_x;
    logic [YW-1:0] dec_y, sat_y, adv_y;
    logic [AW-1:0] cur_addr, ptr_addr, clr_addr, wa;
    logic [DW-1:0] wd, rd_data;
    logic          tex_we, pal_we, ptr_pal, ptr_last;

    function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return AW'(int'(y) * COLS + int'(x));
    endfunction

    assign op       = in[23:16];
    assign dec_x    = in[XW+2:3];
    assign dec_y    = in[YW+2:3];
    assign sat_x    = (dec_x > XMAX) ? XMAX : dec_x;
    assign sat_y    = (dec_y > YMAX) ? YMAX : dec_y;
    assign adv_x    = (cur_x == XMAX) ? '0 : cur_x + 1'b1;
    assign adv_y    = (cur_x != XMAX) ? cur_y : ((cur_y == YMAX) ? '0 : cur_y + 1'b1);
    assign cur_addr = cell_addr(cur_x, cur_y);
    assign ptr_addr = cell_addr(px, py);
    assign clr_addr = cell_addr(loadx, loady);
    assign ptr_pal  = both_q ? ph : pal_only_q;
    assign ptr_last = (px == XMAX) && (py == YMAX) && (!both_q || ph);
    assign rd_data  = ptr_pal ? pal_mem[ptr_addr] : tex_mem[ptr_addr];

    // Single write port per plane: commands only land in IDLE, clears only while streaming.
    always_comb begin
        tex_we = 1'b0;
        pal_we = 1'b0;
        wa     = cur_addr;
        wd     = in[DW-1:0];
        if (rst && state == IDLE && start) begin
            case (op)
                OP_WTEX: tex_we = 1'b1;
                OP_WPAL: pal_we = 1'b1;
                OP_ZERO: begin
                    tex_we = 1'b1;
                    pal_we = 1'b1;
                    wd     = '0;
                end
                default: ;
            endcase
        end else if (rst && CLEAR_ON_FLUSH != 0 && state == STREAM && nstart) begin
            wa     = clr_addr;
            wd     = '0;
            tex_we = !emit_pal_q;
            pal_we = emit_pal_q;
        end
    end

    always_ff @(posedge clk) begin
        if (tex_we) tex_mem[wa] <= wd;
        if (pal_we) pal_mem[wa] <= wd;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cur_x      <= '0;
            cur_y      <= '0;
            px         <= '0;
            py         <= '0;
            ph         <= 1'b0;
            last_q     <= 1'b0;
            both_q     <= 1'b0;
            pal_only_q <= 1'b0;
            emit_pal_q <= 1'b0;
            nin        <= '0;
            nstart     <= 1'b0;
            busy       <= 1'b0;
            irq        <= 1'b0;
            ovf        <= 1'b0;
            loadx      <= '0;
            loady      <= '0;
        end else begin
            nin    <= '0;
            nstart <= 1'b0;
            loadx  <= '0;
            loady  <= '0;
            irq    <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    case (op)
                        OP_SETX: begin
                            cur_x  <= sat_x;
                            nin    <= in;
                            nstart <= 1'b1;
                        end
                        OP_SETY: begin
                            cur_y  <= sat_y;
                            nin    <= in;
                            nstart <= 1'b1;
                        end
                        OP_WTEX, OP_WPAL: if (in[15]) begin
                            cur_x <= adv_x;
                            cur_y <= adv_y;
                        end
                        OP_ZERO: ;
                        OP_FLUSH: begin
                            state      <= PRIME;
                            busy       <= 1'b1;
                            both_q     <= in[1];
                            pal_only_q <= ~in[1] & ~in[0];
                            px         <= '0;
                            py         <= '0;
                            ph         <= 1'b0;
                            last_q     <= 1'b0;
                        end
                        default: begin
                            nin    <= in;
                            nstart <= 1'b1;
                        end
                    endcase
                end
                default: begin
                    if (start) ovf <= 1'b1;
                    // The cycle after the last beat only retires its clear, then signals done.
                    if (state == STREAM && last_q) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        irq   <= 1'b1;
                    end else begin
                        state      <= STREAM;
                        nin        <= {(ptr_pal ? OP_BPAL : OP_BTEX), 16'(rd_data)};
                        nstart     <= 1'b1;
                        loadx      <= px;
                        loady      <= py;
                        emit_pal_q <= ptr_pal;
                        last_q     <= ptr_last;
                        if (both_q && !ph) begin
                            ph <= 1'b1;
                        end else begin
                            ph <= 1'b0;
                            if (px == XMAX) begin
                                px <= '0;
                                py <= (py == YMAX) ? '0 : py + 1'b1;
                            end else begin
                                px <= px + 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/text_flush_buffer.md
TEXT_FLUSH_BUFFER -- requirements
Module: text_flush_buffer

Interface
REQ-001 SHALL have parameters: COLS, default 43, text columns.
REQ-002 SHALL have parameter: ROWS, default 24, text rows.
REQ-003 SHALL have parameter: XW, default 6, column index width; COLS <= 2^XW.
REQ-004 SHALL have parameter: YW, default 5, row index width; ROWS <= 2^YW.
REQ-005 SHALL have parameter: DW, default 8, cell data width; DW <= 16.
REQ-006 SHALL have parameter: CLEAR_ON_FLUSH, default 1, zero each emitted cell.
REQ-007 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-008 SHALL have port: rst  in  1  reset, synchronous, active-low.
REQ-009 SHALL have port: in  in  24  command word; opcode in[23:16].
REQ-010 SHALL have port: start  in  1  command valid, one command per cycle.
REQ-011 SHALL have port: nin  out  24  downstream command word.
REQ-012 SHALL have port: nstart  out  1  downstream valid.
REQ-013 SHALL have port: busy  out  1  flush in progress.
REQ-014 SHALL have port: irq  out  1  one-cycle flush-complete pulse.
REQ-015 SHALL have port: ovf  out  1  sticky: command dropped while busy.
REQ-016 SHALL have ports: loadx  out  XW  and  loady  out  YW, cell of current emission.

Function
REQ-017 SHALL hold two internal planes, TEX and PAL, each COLS*ROWS x DW, with one-cycle registered read, both readable in the same cycle.
REQ-018 SHALL register all outputs; a forwarded command appears on nin/nstart exactly 1 cycle after acceptance.
REQ-019 SHALL, in IDLE with start=1, decode opcodes: 10 set cursor X = in[XW+2:3], forward; 11 set cursor Y = in[YW+2:3], forward; 12 write in[DW-1:0] to TEX at cursor, consume; 13 same to PAL, consume; 254 zero both planes at cursor, consume; 253 begin flush, consume; any other opcode forward unchanged.
REQ-020 SHALL saturate cursor X to COLS-1 and cursor Y to ROWS-1 when the decoded value exceeds them.
REQ-021 SHALL, on opcode 12/13 with in[15]=1, advance cursor after the write: X+1; X wraps COLS-1 -> 0 with Y+1; Y wraps ROWS-1 -> 0.
REQ-022 SHALL take flush mode from in[1:0] of opcode 253: 00 PAL only, 01 TEX only, 10 both, 11 treated as 10.
REQ-023 SHALL implement states IDLE -> PRIME (one cycle, read cell 0,0) -> STREAM -> IDLE.
REQ-024 SHALL scan cells x fastest 0..COLS-1, then y 0..ROWS-1.
REQ-025 SHALL, in STREAM single-plane mode, emit one beat per cycle: nstart=1, nin = {8'd252 (PAL) or 8'd244 (TEX), zero-padded data}, loadx/loady = that cell.
REQ-026 SHALL, in both-plane mode, emit TEX beat then PAL beat for each cell, advancing one cell every 2 cycles.
REQ-027 SHALL, when CLEAR_ON_FLUSH=1, write zero to each emitted plane cell in its emission cycle.
REQ-028 SHALL assert busy from the cycle after flush acceptance through the last emission cycle.
REQ-029 SHALL pulse irq for one cycle in the cycle after the last emission, with busy=0 in that cycle.
REQ-030 SHALL drop any start while busy, produce no output for it, and set ovf; ovf clears only on reset.
REQ-031 SHALL accept a new command in the same cycle irq is high.
REQ-032 SHALL drive nin=0, nstart=0, loadx=0, loady=0 in cycles with no emission or forward.

Reset
REQ-033 SHALL, when rst=0 at a clock edge, set state IDLE, cursor 0,0, nin=0, nstart=0, busy=0, irq=0, ovf=0, loadx=0, loady=0.
REQ-034 SHALL abort a flush on reset mid-operation without irq; plane contents are not reset and partially cleared cells remain as written.

Verification
REQ-035 Defaults: opcode 10 in=0x0A0028 -> cursor X=5; opcode 11 in=0x0B0018 -> Y=3; opcode 12 in=0x0C00AB -> TEX(5,3)=0xAB; both forwards seen 1 cycle later with nstart=1.
REQ-036 Flush mode 01 accepted at T -> busy T+1..T+1033, 1032 beats T+2..T+1033 opcode 244, (5,3) beat data 0xAB, irq at T+1034, second flush reads all zeros.
REQ-037 Flush mode 10 -> 2064 beats alternating 244/252, loadx/loady constant per pair, irq one cycle after last PAL beat.
REQ-038 Auto-increment writes with cursor (42,23) -> write lands at (42,23), cursor wraps to (0,0).
REQ-039 start with opcode 0x55 during flush -> no nstart for it, ovf=1 held until rst=0.
REQ-040 rst=0 at beat 100 of flush -> all outputs zero next cycle, no irq, cells 0..98 read zero afterwards.
